mux_nto1_rr_reg: RTL and testbench
==================================

Name: mux_nto1_rr_reg

Overview:
- Parametrised successor to the 2:1, 2-bit gate-level multiplexer.
- Selects one of N W-bit channels and registers the result into a one-deep output stage with a valid/ready handshake.
- Two modes:
  - Fixed select: the channel is chosen by the sel input.
  - Round-robin: the block arbitrates fairly among channels presenting valid data.
- Sits between N producers and one downstream consumer in the datapath.

Parameters:
- N, 4: number of input channels (2..16).
- W, 2: data width per channel in bits (>=1).
- SELW, clog2(N), minimum 1: width of sel and grant_id. Derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- data_in  input  N*W  channel i occupies bits [i*W +: W].
- valid_in  input  N  per-channel data valid.
- ready_in  output  N  per-channel accept (combinational).
- data_out  output  W  registered selected data.
- valid_out  output  1  data_out holds a word.
- ready_out  input  1  consumer accepts data_out this cycle.
- grant_id  output  SELW  index of the channel that supplied data_out.

Behaviour:
- Reset is sampled on the clk edge only. On reset:
  - data_out = 0, valid_out = 0, grant_id = 0, round-robin pointer ptr = 0.
  - Reset asserted mid-operation discards the held word.
- load_en = !valid_out || ready_out. The output stage may load a new word only when load_en is 1.
- Candidate, fixed mode: cand = sel. If sel >= N, there is no candidate.
- Candidate, round-robin mode: cand = first index i with valid_in[i] = 1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1. If no valid_in bit is set, there is no candidate.
- ready_in[i] = load_en && candidate exists && (i == cand). At most one bit is ever set.
  - In fixed mode ready_in[sel] may be 1 while valid_in[sel] = 0.
- Transfer occurs on valid_in[cand] && ready_in[cand]. On the next edge:
  - data_out <= data_in[cand].
  - valid_out <= 1.
  - grant_id <= cand.
  - In round-robin mode: ptr <= cand+1, wrapping N-1 -> 0.
- load_en = 1 with no transfer: valid_out <= 0. data_out and grant_id hold their last values.
- load_en = 0 (valid_out = 1, ready_out = 0): data_out, grant_id and valid_out are held stable. No ready_in bit is set.
- Latency is 1 cycle from transfer to valid_out.
- Throughput is 1 word/cycle with no bubble when ready_out is held at 1. Drain and refill in the same cycle is required.
- ptr changes only on a round-robin transfer. In fixed mode ptr is frozen.
- A mode or sel change takes effect combinationally in the same cycle. The held word is unaffected.
- Fairness: with all N channels continuously valid and ready_out = 1, grants rotate 0,1,...,N-1,0,... Each channel is served once every N cycles.
- data_in is don't-care when the matching valid_in bit is 0. data_out must not change on such a channel.

Decomposition:
- Shared package/header (include-guarded) holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - The clog2 helper function used to derive SELW.
- One sub-module, rr_arbiter_nchan (parameter N). It contains:
  - Inputs: req[N], enable, advance.
  - Outputs: grant_onehot[N], grant_idx[SELW], any_grant.
  - Internal: the ptr register, with the same synchronous reset.
- The top level contains:
  - Fixed/RR candidate selection.
  - ready_in decode.
  - Output register and handshake.

Test Plan (N=4, W=2):
1. Reset: hold reset high for 2 cycles with all inputs active -> valid_out=0, data_out=2'b00, grant_id=0, ready_in=4'b0000 during reset; ptr=0 afterwards.
2. Fixed mode: mode=0, sel=2, valid_in=4'b1111, data_in={2'b11,2'b10,2'b01,2'b00}, ready_out=1 -> ready_in=4'b0100; next cycle data_out=2'b10, valid_out=1, grant_id=2. Then sel=3 -> ready_in=4'b1000.
3. Round-robin rotation: mode=1, valid_in=4'b1111, ready_out=1 for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3 with valid_out=1 every cycle after the first.
4. Round-robin skip: mode=1, valid_in=4'b1010, ptr=0 -> grants 1,3,1,3. Then valid_in=4'b0000 -> valid_out drops to 0 the next cycle.
5. Backpressure: a word is held with ready_out=0 for 3 cycles while valid_in=4'b1111 -> data_out/grant_id stable, ready_in=4'b0000. ready_out=1 -> the next word loads in the same cycle as the drain, with no bubble.
6. Reset mid-stream: assert reset while valid_out=1, ready_out=0, ptr=2 -> next cycle valid_out=0, data_out=0, ptr=0. The first grant after reset in round-robin mode with valid_in=4'b1111 is channel 0.

Source files
------------

// File: rtl/mux_nto1_rr_reg_pkg.sv
// ============================================================================
// Module   : mux_nto1_rr_reg_pkg
// Brief    : Shared mode encodings and select-width helpers for mux_nto1_rr_reg.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef MUX_NTO1_RR_REG_PKG_SV
`define MUX_NTO1_RR_REG_PKG_SV

`default_nettype none

package mux_nto1_rr_reg_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A single channel still needs a one-bit index field.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

`default_nettype wire

`endif

// File: rtl/mux_nto1_rr_arbiter_nchan.sv
// ============================================================================
// Module   : rr_arbiter_nchan
// Brief    : N-way round-robin arbiter; searches from ptr upward and wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_nchan
    import mux_nto1_rr_reg_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            enable,
    input  logic            advance,
    output logic [N-1:0]    grant_onehot,
    output logic [SELW-1:0] grant_idx,
    output logic            any_grant
);

    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_idx;
    logic            w_found;

    // Rotating priority search: the first requester at or after r_ptr wins.
    always_comb begin
        logic [SELW:0] v_pos;
        w_idx   = '0;
        w_found = 1'b0;
        v_pos   = '0;
        for (int k = 0; k < N; k++) begin
            v_pos = {1'b0, r_ptr} + (SELW+1)'(k);
            if (v_pos >= (SELW+1)'(N)) begin
                v_pos = v_pos - (SELW+1)'(N);
            end
            if (!w_found && req[v_pos[SELW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = v_pos[SELW-1:0];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (enable && w_found) begin
            grant_onehot[w_idx] = 1'b1;
        end
    end

    assign grant_idx = w_idx;
    assign any_grant = enable && w_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (w_idx == SELW'(N-1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_nto1_rr_reg.sv
// ============================================================================
// Module   : mux_nto1_rr_reg
// Brief    : N:1 W-bit mux (fixed select or round-robin) into a one-deep
//            valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nto1_rr_reg
    import mux_nto1_rr_reg_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 2,
    localparam int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  data_in,
    input  logic [N-1:0]    valid_in,
    output logic [N-1:0]    ready_in,
    output logic [W-1:0]    data_out,
    output logic            valid_out,
    input  logic            ready_out,
    output logic [SELW-1:0] grant_id
);

    logic [W-1:0]    r_data_out;
    logic            r_valid_out;
    logic [SELW-1:0] r_grant_id;

    logic            w_is_rr;
    logic            w_is_fixed;
    logic            w_load_en;
    logic            w_sel_in_range;
    logic [N-1:0]    w_fixed_onehot;
    logic [N-1:0]    w_rr_onehot;
    logic [SELW-1:0] w_rr_idx;
    logic            w_rr_any;
    logic [N-1:0]    w_cand_onehot;
    logic [SELW-1:0] w_cand;
    logic            w_cand_ok;
    logic [W-1:0]    w_cand_data;
    logic            w_xfer;

    assign w_is_rr        = (mode == MODE_RR);
    assign w_is_fixed     = (mode == MODE_FIXED);
    assign w_load_en      = !r_valid_out || ready_out;
    assign w_sel_in_range = ({1'b0, sel} < (SELW+1)'(N));

    generate
        for (genvar i = 0; i < N; i++) begin : g_fixed_dec
            assign w_fixed_onehot[i] = w_is_fixed && w_sel_in_range && (sel == SELW'(i));
        end
    endgenerate

    rr_arbiter_nchan #(
        .N (N)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .req          (valid_in),
        .enable       (w_is_rr),
        .advance      (w_xfer && w_is_rr),
        .grant_onehot (w_rr_onehot),
        .grant_idx    (w_rr_idx),
        .any_grant    (w_rr_any)
    );

    assign w_cand_onehot = w_is_rr ? w_rr_onehot : w_fixed_onehot;
    assign w_cand        = w_is_rr ? w_rr_idx    : sel;
    assign w_cand_ok     = w_is_rr ? w_rr_any    : w_sel_in_range;

    // Nothing is offered while in reset, since the register would drop it.
    assign ready_in = (!reset && w_load_en && w_cand_ok) ? w_cand_onehot : '0;
    assign w_xfer   = |(ready_in & valid_in);

    always_comb begin
        w_cand_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_cand_onehot[i]) begin
                w_cand_data = data_in[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_grant_id  <= '0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_data_out  <= w_cand_data;
                r_valid_out <= 1'b1;
                r_grant_id  <= w_cand;
            end else begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign grant_id  = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_mux_nto1_rr_reg.sv
// ============================================================================
// Module   : tb_mux_nto1_rr_reg
// Brief    : Directed self-checking bench for mux_nto1_rr_reg (N=4, W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_nto1_rr_reg;

    localparam int N    = 4;
    localparam int W    = 2;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [N*W-1:0]  data_in;
    logic [N-1:0]    valid_in;
    logic [N-1:0]    ready_in;
    logic [W-1:0]    data_out;
    logic            valid_out;
    logic            ready_out;
    logic [SELW-1:0] grant_id;

    int vectors     = 0;
    int miscompares = 0;

    mux_nto1_rr_reg #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [W-1:0] d,
                             input logic [SELW-1:0] g);
        check({tag, ".valid_out"}, 32'(valid_out), 32'(v));
        check({tag, ".data_out"},  32'(data_out),  32'(d));
        check({tag, ".grant_id"},  32'(grant_id),  32'(g));
    endtask

    initial begin
        // Channel i carries the value i.
        reset     = 1'b1;
        mode      = 1'b1;
        sel       = 2'd2;
        data_in   = 8'b11_10_01_00;
        valid_in  = 4'b1111;
        ready_out = 1'b1;

        tick();
        check_out("rst0", 1'b0, 2'b00, 2'd0);
        check("rst0.ready_in", 32'(ready_in), 32'h0);
        tick();
        check_out("rst1", 1'b0, 2'b00, 2'd0);
        check("rst1.ready_in", 32'(ready_in), 32'h0);

        // Fixed select
        reset = 1'b0;
        mode  = 1'b0;
        sel   = 2'd2;
        #1;
        check("fix2.ready_in", 32'(ready_in), 32'b0100);
        tick();
        check_out("fix2", 1'b1, 2'b10, 2'd2);
        sel = 2'd3;
        #1;
        check("fix3.ready_in", 32'(ready_in), 32'b1000);
        tick();
        check_out("fix3", 1'b1, 2'b11, 2'd3);

        // Round-robin rotation; ptr stayed at 0 through fixed mode
        mode = 1'b1;
        #1;
        check("rr.ready_in", 32'(ready_in), 32'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_out($sformatf("rr%0d", i), 1'b1, 2'(i % 4), 2'(i % 4));
        end

        // Round-robin skip over idle channels
        valid_in = 4'b1010;
        #1;
        check("skip.ready_in", 32'(ready_in), 32'b0010);
        tick();
        check_out("skip0", 1'b1, 2'b01, 2'd1);
        tick();
        check_out("skip1", 1'b1, 2'b11, 2'd3);
        tick();
        check_out("skip2", 1'b1, 2'b01, 2'd1);
        tick();
        check_out("skip3", 1'b1, 2'b11, 2'd3);
        valid_in = 4'b0000;
        #1;
        check("idle.ready_in", 32'(ready_in), 32'h0);
        tick();
        check_out("idle", 1'b0, 2'b11, 2'd3);

        // Backpressure: hold channel 0's word while inputs change underneath
        valid_in = 4'b1111;
        tick();
        check_out("bp.load", 1'b1, 2'b00, 2'd0);
        ready_out = 1'b0;
        data_in   = 8'b00_01_10_11;
        #1;
        check("bp.ready_in", 32'(ready_in), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("bp.hold%0d", i), 1'b1, 2'b00, 2'd0);
            check($sformatf("bp.hold%0d.ready_in", i), 32'(ready_in), 32'h0);
        end
        ready_out = 1'b1;
        #1;
        check("bp.release.ready_in", 32'(ready_in), 32'b0010);
        tick();
        check_out("bp.refill", 1'b1, 2'b10, 2'd1);

        // Reset mid-stream with a held word and ptr at 2
        ready_out = 1'b0;
        tick();
        check_out("pre_rst.hold", 1'b1, 2'b10, 2'd1);
        reset = 1'b1;
        tick();
        check_out("mid_rst", 1'b0, 2'b00, 2'd0);
        reset     = 1'b0;
        ready_out = 1'b1;
        #1;
        check("post_rst.ready_in", 32'(ready_in), 32'b0001);
        tick();
        check_out("post_rst", 1'b1, 2'b11, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
